// File: rtl/eth_stats_accumulator_tx.sv
// Per-port TX statistics accumulator with request/acknowledge snapshot.
// Two-stage pipeline: event capture, then counter update.
module eth_stats_accumulator_tx #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      frame_bytes,
    input  logic             frame_good,
    input  logic             valid,
    input  logic             clear,
    input  logic             snapshot_req,
    output logic             snapshot_ack,
    output logic [CNT_W-1:0] total_bytes,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames,
    output logic [15:0]      min_good_bytes,
    output logic [15:0]      max_good_bytes,
    output logic [CNT_W-1:0] snap_bytes,
    output logic [CNT_W-1:0] snap_good,
    output logic [CNT_W-1:0] snap_bad,
    output logic [15:0]      snap_min,
    output logic [15:0]      snap_max
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        load;
    logic        ev_valid;
    logic [15:0] ev_bytes;
    logic        ev_good;

    // Stage 1: capture the frame event; clear drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid <= 1'b0;
            ev_bytes <= 16'd0;
            ev_good  <= 1'b0;
        end else begin
            ev_valid <= valid & ~clear;
            if (valid) begin
                ev_bytes <= frame_bytes;
                ev_good  <= frame_good;
            end
        end
    end

    // Stage 2: live counters, clear wins over an update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_bytes    <= '0;
            good_frames    <= '0;
            bad_frames     <= '0;
            min_good_bytes <= 16'hFFFF;
            max_good_bytes <= 16'h0000;
        end else if (clear) begin
            total_bytes    <= '0;
            good_frames    <= '0;
            bad_frames     <= '0;
            min_good_bytes <= 16'hFFFF;
            max_good_bytes <= 16'h0000;
        end else if (ev_valid) begin
            total_bytes <= total_bytes + CNT_W'(ev_bytes);
            if (ev_good) begin
                good_frames <= good_frames + CNT_W'(1);
                if (ev_bytes < min_good_bytes) begin
                    min_good_bytes <= ev_bytes;
                end
                if (ev_bytes > max_good_bytes) begin
                    max_good_bytes <= ev_bytes;
                end
            end else begin
                bad_frames <= bad_frames + CNT_W'(1);
            end
        end
    end

    // Snapshot FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot FSM next state; requests are ignored while loading
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (snapshot_req) state_nxt = LOAD;
            LOAD: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot FSM outputs
    always_comb begin
        load = (state == LOAD);
    end

    // Snapshot copy takes pre-edge live values, so it sees pre-clear state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_bytes   <= '0;
            snap_good    <= '0;
            snap_bad     <= '0;
            snap_min     <= 16'hFFFF;
            snap_max     <= 16'h0000;
            snapshot_ack <= 1'b0;
        end else begin
            snapshot_ack <= load;
            if (load) begin
                snap_bytes <= total_bytes;
                snap_good  <= good_frames;
                snap_bad   <= bad_frames;
                snap_min   <= min_good_bytes;
                snap_max   <= max_good_bytes;
            end
        end
    end

endmodule
